// File: rtl/pipelined_control_unit.sv
// RV32I control path: Decode-stage decoder plus ID/EX, EX/MEM, MEM/WB control registers with flush-to-bubble.
// Optional macro CTRL_ILLEGAL_TRAP_EN builds the Execute-stage illegal-encoding flag.
module pipelined_control_unit #(
  parameter int unsigned ALU_CTRL_W = 4,
  parameter int unsigned IMM_SRC_W  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           instr_d,
  input  logic                  flush_e,
  input  logic                  zero_e,
  input  logic                  lt_e,
  input  logic                  ltu_e,
  output logic [IMM_SRC_W-1:0]  imm_src_d,
  output logic [ALU_CTRL_W-1:0] alu_control_e,
  output logic                  alu_src_e,
  output logic                  alu_a_src_e,
  output logic                  pc_src_e,
  output logic                  jalr_e,
  output logic [1:0]            result_src_e,
  output logic                  mem_write_m,
  output logic                  reg_write_m,
  output logic                  reg_write_w,
  output logic [1:0]            result_src_w,
  output logic                  illegal_e
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic [3:0] alu_control;
    logic       alu_src;
    logic       alu_a_src;
    logic [2:0] funct3;
  } ex_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
  } mem_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
  } wb_ctrl_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic [2:0] imm_sel;
  logic       dec_illegal;
  ex_ctrl_t   dec;
  ex_ctrl_t   ex_d, ex_q;
  mem_ctrl_t  mem_d, mem_q;
  wb_ctrl_t   wb_d, wb_q;
  logic       br_cond;
  logic       unused_instr;

  assign opcode       = instr_d[6:0];
  assign funct3       = instr_d[14:12];
  assign funct7_5     = instr_d[30];
  assign unused_instr = ^{instr_d[31], instr_d[29:15], instr_d[11:7]};

  // funct7_5 selects sub only for register ops; it always selects sra on shifts.
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic f7_5, input logic is_reg);
    alu_op = ALU_ADD;
    case (f3)
      3'b000:  alu_op = (is_reg && f7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = f7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

  // Decode; anything unsupported stays an all-zero bubble.
  always_comb begin
    dec         = '0;
    imm_sel     = IMM_I;
    dec_illegal = 1'b0;
    case (opcode)
      OP_LUI: begin
        dec.reg_write  = 1'b1;
        dec.result_src = RES_IMM;
        imm_sel        = IMM_U;
      end
      OP_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_a_src = 1'b1;
        imm_sel       = IMM_U;
      end
      OP_JAL: begin
        dec.reg_write  = 1'b1;
        dec.result_src = RES_PC4;
        dec.jump       = 1'b1;
        imm_sel        = IMM_J;
      end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          dec.reg_write  = 1'b1;
          dec.result_src = RES_PC4;
          dec.jump       = 1'b1;
          dec.jalr       = 1'b1;
          dec.alu_src    = 1'b1;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OP_BRANCH: begin
        if (funct3[2:1] != 2'b01) begin
          dec.branch      = 1'b1;
          dec.alu_control = ALU_SUB;
          imm_sel         = IMM_B;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OP_LOAD: begin
        if (funct3 == 3'b010) begin
          dec.reg_write  = 1'b1;
          dec.result_src = RES_MEM;
          dec.alu_src    = 1'b1;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OP_STORE: begin
        if (funct3 == 3'b010) begin
          dec.mem_write = 1'b1;
          dec.alu_src   = 1'b1;
          imm_sel       = IMM_S;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OP_IMM: begin
        dec.reg_write   = 1'b1;
        dec.alu_src     = 1'b1;
        dec.alu_control = alu_op(funct3, funct7_5, 1'b0);
      end
      OP_REG: begin
        dec.reg_write   = 1'b1;
        dec.alu_control = alu_op(funct3, funct7_5, 1'b1);
      end
      default: dec_illegal = 1'b1;
    endcase
    if (!dec_illegal) dec.funct3 = funct3;
  end

  assign imm_src_d = IMM_SRC_W'(imm_sel);

  // Stage advance; flush only bubbles E, the old E contents still move on.
  always_comb begin
    ex_d  = flush_e ? '0 : dec;
    mem_d = '{reg_write: ex_q.reg_write, result_src: ex_q.result_src, mem_write: ex_q.mem_write};
    wb_d  = '{reg_write: mem_q.reg_write, result_src: mem_q.result_src};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  // Branch resolution against live Execute flags.
  always_comb begin
    br_cond = 1'b0;
    case (ex_q.funct3)
      3'b000:  br_cond = zero_e;
      3'b001:  br_cond = !zero_e;
      3'b100:  br_cond = lt_e;
      3'b101:  br_cond = !lt_e;
      3'b110:  br_cond = ltu_e;
      3'b111:  br_cond = !ltu_e;
      default: br_cond = 1'b0;
    endcase
    pc_src_e = ex_q.jump | (ex_q.branch & br_cond);
  end

  assign alu_control_e = ALU_CTRL_W'(ex_q.alu_control);
  assign alu_src_e     = ex_q.alu_src;
  assign alu_a_src_e   = ex_q.alu_a_src;
  assign jalr_e        = ex_q.jalr;
  assign result_src_e  = ex_q.result_src;
  assign mem_write_m   = mem_q.mem_write;
  assign reg_write_m   = mem_q.reg_write;
  assign reg_write_w   = wb_q.reg_write;
  assign result_src_w  = wb_q.result_src;

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_d, illegal_q;

  always_comb begin
    illegal_d = flush_e ? 1'b0 : dec_illegal;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) illegal_q <= 1'b0;
    else       illegal_q <= illegal_d;
  end

  assign illegal_e = illegal_q;
`else
  logic unused_illegal;
  assign unused_illegal = dec_illegal;
  assign illegal_e      = 1'b0;
`endif

endmodule
